// File: rtl/poly_cap_pkg.sv
// Shared types and sizing helpers for the POLY_MAU result-capture block.
package poly_cap_pkg;

    localparam int DEFAULT_DW = 24;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        CAPT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Bits needed to hold a count in the range 0..n inclusive.
    function automatic int cnt_w(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/poly_result_capture_if.sv
// Capture-side bus: POLY_MAU results in, FIFO head/status and debug state out.
// Handshake: poly_valid qualifies o0/o1 for one cycle (no backpressure); rd_pop consumes head when !empty.
interface poly_result_capture_if
    import poly_cap_pkg::*;
#(
    parameter int DW    = DEFAULT_DW,
    parameter int DEPTH = 4
);
    localparam int CW = cnt_w(DEPTH);

    logic          cap_start;
    logic          poly_valid;
    logic [DW-1:0] poly_mau_o0;
    logic [DW-1:0] poly_mau_o1;
    logic          rd_pop;
    logic [DW-1:0] head_o0;
    logic [DW-1:0] head_o1;
    logic [CW-1:0] fifo_cnt;
    logic          empty;
    logic          busy;
    logic          done;
    logic          timeout;
    logic          extra;
    state_t        state;

    modport master (
        output cap_start, poly_valid, poly_mau_o0, poly_mau_o1, rd_pop,
        input  head_o0, head_o1, fifo_cnt, empty, busy, done, timeout, extra, state
    );

    modport slave (
        input  cap_start, poly_valid, poly_mau_o0, poly_mau_o1, rd_pop,
        output head_o0, head_o1, fifo_cnt, empty, busy, done, timeout, extra, state
    );

endinterface

// File: rtl/poly_result_capture_fifo.sv
// Synchronous show-ahead FIFO; dout presents the head entry and reads as 0 when empty.
module poly_result_fifo
    import poly_cap_pkg::*;
#(
    parameter int W     = 2 * DEFAULT_DW,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    push,
    input  logic                    pop,
    input  logic [W-1:0]            din,
    output logic [W-1:0]            dout,
    output logic [cnt_w(DEPTH)-1:0] cnt,
    output logic                    empty,
    output logic                    full
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push;
    logic          do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == FULL_CNT);
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
        else if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && !clr && do_push) mem_q[wr_ptr_q] <= din;
    end

    assign dout = empty ? '0 : mem_q[rd_ptr_q];
    assign cnt  = cnt_q;

endmodule

// File: rtl/poly_result_capture.sv
// Arms on cap_start, captures NRES POLY_MAU result pairs into a show-ahead FIFO, flags timeout/extra.
module poly_result_capture
    import poly_cap_pkg::*;
#(
    parameter int DW      = DEFAULT_DW,
    parameter int DEPTH   = 4,
    parameter int NRES    = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    poly_result_capture_if.slave  bus
);
    localparam int TW = cnt_w(TIMEOUT);
    localparam int RW = cnt_w(NRES);
    localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);
    localparam logic [RW-1:0] RES_LAST = RW'(NRES - 1);

    state_t        state_q;
    logic [TW-1:0] timer_q;
    logic [RW-1:0] captured_q;
    logic          timeout_q;
    logic          extra_q;

    logic               fifo_clr;
    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [2*DW-1:0]    fifo_dout;

    // cap_start flushes and wins over any valid or pop in the same cycle.
    assign fifo_clr  = bus.cap_start;
    assign fifo_push = bus.poly_valid && !bus.cap_start &&
                       ((state_q == ARMED) || (state_q == CAPT));
    assign fifo_pop  = bus.rd_pop && !bus.cap_start;

    poly_result_fifo #(
        .W     (2 * DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (fifo_clr),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   ({bus.poly_mau_o1, bus.poly_mau_o0}),
        .dout  (fifo_dout),
        .cnt   (bus.fifo_cnt),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            captured_q <= '0;
            timeout_q  <= 1'b0;
            extra_q    <= 1'b0;
        end else if (bus.cap_start) begin
            state_q    <= ARMED;
            timer_q    <= '0;
            captured_q <= '0;
            timeout_q  <= 1'b0;
            extra_q    <= 1'b0;
        end else begin
            case (state_q)
                ARMED, CAPT: begin
                    if (bus.poly_valid) begin
                        timer_q    <= '0;
                        captured_q <= captured_q + 1'b1;
                        if (state_q == ARMED && NRES != 1) state_q <= CAPT;
                        else if (captured_q == RES_LAST)   state_q <= DONE;
                    end else if (timer_q == TMR_LAST) begin
                        state_q   <= DONE;
                        timeout_q <= 1'b1;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.poly_valid) extra_q <= 1'b1;
                end
                default: ;
            endcase
            if (fifo_push && fifo_full && !fifo_pop) extra_q <= 1'b1;
        end
    end

    assign bus.head_o0 = fifo_dout[DW-1:0];
    assign bus.head_o1 = fifo_dout[2*DW-1:DW];
    assign bus.empty   = fifo_empty;
    assign bus.busy    = (state_q == ARMED) || (state_q == CAPT);
    assign bus.done    = (state_q == DONE);
    assign bus.timeout = timeout_q;
    assign bus.extra   = extra_q;
    assign bus.state   = state_q;

endmodule
